// File: rtl/cache_tag_ctrl_pkg.sv
// Shared sizes, FSM state encoding and a lowest-set-bit helper for the cache tag controller.
package cache_tag_ctrl_pkg;

  localparam int N       = 4;
  localparam int LOG_W   = 2;
  localparam int LOG_H   = 8;
  localparam int TAG_LEN = 20;
  localparam int H       = 1 << LOG_H;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    RF_REQ  = 3'd2,
    RF_WAIT = 3'd3,
    WRITE   = 3'd4
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [LOG_W-1:0] lowest_way(input logic [N-1:0] vec);
    lowest_way = '0;
    for (int w = N - 1; w >= 0; w--) begin
      if (vec[w]) lowest_way = LOG_W'(w);
    end
  endfunction

endpackage

// File: rtl/cache_tag_ctrl_repl_sel.sv
// Replacement state and victim choice. Default: one global round-robin counter.
// CACHE_TAG_CTRL_PLRU_EN selects a per-set 3-bit tree-PLRU instead.
module cache_repl_sel
  import cache_tag_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [LOG_H-1:0] rd_index,
  output logic [LOG_W-1:0] victim,
  input  logic             upd_en,
  input  logic             upd_from_repl,
  input  logic [LOG_H-1:0] upd_index,
  input  logic [LOG_W-1:0] upd_way
);

`ifdef CACHE_TAG_CTRL_PLRU_EN
  // bit0 = root (0 -> ways 0/1), bit1 = ways 0/1, bit2 = ways 2/3
  logic [2:0] plru_q [H];
  logic [2:0] rd_bits;
  logic [2:0] plru_d;
  logic       unused_plru;

  assign unused_plru = upd_from_repl;

  always_comb begin
    rd_bits = plru_q[rd_index];
    victim  = rd_bits[0] ? {1'b1, rd_bits[2]} : {1'b0, rd_bits[1]};
  end

  always_comb begin
    plru_d = plru_q[upd_index];
    if (!upd_way[1]) begin
      plru_d[0] = 1'b1;
      plru_d[1] = ~upd_way[0];
    end else begin
      plru_d[0] = 1'b0;
      plru_d[2] = ~upd_way[0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < H; i++) plru_q[i] <= '0;
    end else if (upd_en) begin
      plru_q[upd_index] <= plru_d;
    end
  end
`else
  logic [LOG_W-1:0] rr_q, rr_d;
  logic             unused_rr;

  // Index and way do not matter for a single global pointer.
  assign unused_rr = ^{rd_index, upd_index, upd_way};
  assign victim    = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (upd_en && upd_from_repl) rr_d = rr_q + 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`endif

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag-side lookup/refill controller for a 4-way set-associative cache.
// Optional macro CACHE_TAG_CTRL_PLRU_EN switches replacement to per-set tree-PLRU.
//
//   state   | meaning
//   IDLE    | ready for a lookup request
//   LOOKUP  | compare latched tag against tr_dout
//   RF_REQ  | refill request offered, waiting for rf_req_ready
//   RF_WAIT | refill in flight, waiting for rf_done
//   WRITE   | write new tag, set valid, miss response
module cache_tag_ctrl
  import cache_tag_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LOG_H-1:0]       req_index,
  input  logic [TAG_LEN-1:0]     req_tag,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [LOG_W-1:0]       resp_way,
  output logic                   tr_we,
  output logic [LOG_W-1:0]       tr_way,
  output logic [LOG_H-1:0]       tr_addr,
  output logic [TAG_LEN-1:0]     tr_din,
  input  logic [N*TAG_LEN-1:0]   tr_dout,
  output logic                   rf_req_valid,
  input  logic                   rf_req_ready,
  output logic [LOG_H-1:0]       rf_req_index,
  output logic [TAG_LEN-1:0]     rf_req_tag,
  output logic [LOG_W-1:0]       rf_req_way,
  input  logic                   rf_done
);

  state_e               state_q, state_d;
  logic [LOG_H-1:0]     idx_q, idx_d;
  logic [TAG_LEN-1:0]   tag_q, tag_d;
  logic [LOG_W-1:0]     victim_q, victim_d;
  logic                 from_repl_q, from_repl_d;

  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [LOG_W-1:0]     resp_way_q, resp_way_d;
  logic                 tr_we_q, tr_we_d;
  logic [LOG_W-1:0]     tr_way_q, tr_way_d;
  logic                 rf_req_valid_q, rf_req_valid_d;

  logic [N-1:0]         valid_q [H];
  logic [N-1:0]         set_valid_bits;
  logic [N-1:0]         hit_vec;
  logic                 set_valid;

  logic [LOG_W-1:0]     repl_victim;
  logic                 upd_en;
  logic                 upd_from_repl;
  logic [LOG_W-1:0]     upd_way;

  assign tr_addr      = idx_q;
  assign tr_din       = tag_q;
  assign rf_req_index = idx_q;
  assign rf_req_tag   = tag_q;
  assign rf_req_way   = victim_q;

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign resp_way     = resp_way_q;
  assign tr_we        = tr_we_q;
  assign tr_way       = tr_way_q;
  assign rf_req_valid = rf_req_valid_q;

  cache_repl_sel u_repl (
    .clk           (clk),
    .resetn        (resetn),
    .rd_index      (idx_q),
    .victim        (repl_victim),
    .upd_en        (upd_en),
    .upd_from_repl (upd_from_repl),
    .upd_index     (idx_q),
    .upd_way       (upd_way)
  );

  always_comb begin
    set_valid_bits = valid_q[idx_q];
    for (int w = 0; w < N; w++) begin
      hit_vec[w] = set_valid_bits[w] && (tr_dout[w*TAG_LEN +: TAG_LEN] == tag_q);
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tag_d          = tag_q;
    victim_d       = victim_q;
    from_repl_d    = from_repl_q;
    req_ready_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_hit_d     = 1'b0;
    resp_way_d     = '0;
    tr_we_d        = 1'b0;
    tr_way_d       = '0;
    rf_req_valid_d = 1'b0;
    set_valid      = 1'b0;
    upd_en         = 1'b0;
    upd_from_repl  = 1'b0;
    upd_way        = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          idx_d       = req_index;
          tag_d       = req_tag;
          req_ready_d = 1'b0;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (|hit_vec) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_way_d   = lowest_way(hit_vec);
          upd_en       = 1'b1;
          upd_way      = lowest_way(hit_vec);
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          // Prefer an empty way; only a full set consults the policy.
          from_repl_d    = &set_valid_bits;
          victim_d       = (&set_valid_bits) ? repl_victim : lowest_way(~set_valid_bits);
          rf_req_valid_d = 1'b1;
          state_d        = RF_REQ;
        end
      end
      RF_REQ: begin
        rf_req_valid_d = 1'b1;
        if (rf_req_ready) begin
          rf_req_valid_d = 1'b0;
          state_d        = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (rf_done) begin
          tr_we_d       = 1'b1;
          tr_way_d      = victim_q;
          resp_valid_d  = 1'b1;
          resp_way_d    = victim_q;
          set_valid     = 1'b1;
          upd_en        = 1'b1;
          upd_way       = victim_q;
          upd_from_repl = from_repl_q;
          state_d       = WRITE;
        end
      end
      WRITE: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      tag_q          <= '0;
      victim_q       <= '0;
      from_repl_q    <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      tr_we_q        <= 1'b0;
      tr_way_q       <= '0;
      rf_req_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tag_q          <= tag_d;
      victim_q       <= victim_d;
      from_repl_q    <= from_repl_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_hit_q     <= resp_hit_d;
      resp_way_q     <= resp_way_d;
      tr_we_q        <= tr_we_d;
      tr_way_q       <= tr_way_d;
      rf_req_valid_q <= rf_req_valid_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < H; i++) valid_q[i] <= '0;
    end else if (set_valid) begin
      valid_q[idx_q][victim_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Randomized bench for cache_tag_ctrl against a transaction-level cache model.
module tb_cache_tag_ctrl;

  localparam int TL = 20;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid, req_ready;
  logic [7:0]    req_index;
  logic [TL-1:0] req_tag;
  logic          resp_valid, resp_hit;
  logic [1:0]    resp_way;
  logic          tr_we;
  logic [1:0]    tr_way;
  logic [7:0]    tr_addr;
  logic [TL-1:0] tr_din;
  logic [4*TL-1:0] tr_dout;
  logic          rf_req_valid, rf_req_ready;
  logic [7:0]    rf_req_index;
  logic [TL-1:0] rf_req_tag;
  logic [1:0]    rf_req_way;
  logic          rf_done;

  int checks = 0;
  int failures = 0;

  cache_tag_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .tr_we(tr_we), .tr_way(tr_way), .tr_addr(tr_addr), .tr_din(tr_din), .tr_dout(tr_dout),
    .rf_req_valid(rf_req_valid), .rf_req_ready(rf_req_ready), .rf_req_index(rf_req_index),
    .rf_req_tag(rf_req_tag), .rf_req_way(rf_req_way), .rf_done(rf_done)
  );

  always #5 clk = ~clk;

  // Tag RAM: combinational read, written by the controller; set 5 starts all-zero.
  logic [TL-1:0] tram [256][4];
  logic          tram_init = 1'b1;
  assign tr_dout = {tram[tr_addr][3], tram[tr_addr][2], tram[tr_addr][1], tram[tr_addr][0]};
  always @(posedge clk) begin
    if (tram_init) begin
      for (int i = 0; i < 256; i++)
        for (int w = 0; w < 4; w++)
          tram[i][w] <= (i == 5) ? '0 : TL'($urandom_range(0, 5));
    end else if (tr_we) begin
      tram[tr_addr][tr_way] <= tr_din;
    end
  end

  // Cache model
  bit            mvalid [256][4];
  logic [TL-1:0] mtag   [256][4];
  int            rr;
  logic [2:0]    plru   [256];

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      for (int w = 0; w < 4; w++) mvalid[i][w] = 1'b0;
      plru[i] = 3'b000;
    end
    rr = 0;
  endtask

  function automatic int policy_victim(input int idx);
`ifdef CACHE_TAG_CTRL_PLRU_EN
    logic [2:0] b;
    b = plru[idx];
    if (b[0]) return b[2] ? 3 : 2;
    return b[1] ? 1 : 0;
`else
    if (idx < 0) return 0;
    return rr;
`endif
  endfunction

  task automatic touch(input int idx, input int w, input bit from_repl);
`ifdef CACHE_TAG_CTRL_PLRU_EN
    if (w < 2) begin
      plru[idx][0] = 1'b1;
      plru[idx][1] = (w == 0);
    end else begin
      plru[idx][0] = 1'b0;
      plru[idx][2] = (w == 2);
    end
`else
    if (from_repl && idx >= 0 && w >= 0) rr = (rr + 1) % 4;
`endif
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Per-cycle expectations used by the compare process
  logic          chk_en = 1'b0;
  logic          exp_ready, exp_rv, exp_hit, exp_we, exp_rf, exp_addr_chk;
  logic [1:0]    exp_way;
  logic [7:0]    exp_idx;
  logic [TL-1:0] exp_tag;

  task automatic set_exp(input logic rdy, input logic rv, input logic hit, input logic [1:0] way,
                         input logic we, input logic rf, input logic addr_chk);
    exp_ready = rdy; exp_rv = rv; exp_hit = hit; exp_way = way;
    exp_we = we; exp_rf = rf; exp_addr_chk = addr_chk;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("resp_hit", 32'(resp_hit), 32'(exp_hit));
        chk("resp_way", 32'(resp_way), 32'(exp_way));
      end
      chk("tr_we", 32'(tr_we), 32'(exp_we));
      if (exp_we) begin
        chk("tr_way", 32'(tr_way), 32'(exp_way));
        chk("tr_din", 32'(tr_din), 32'(exp_tag));
      end
      chk("rf_req_valid", 32'(rf_req_valid), 32'(exp_rf));
      if (exp_rf) begin
        chk("rf_req_index", 32'(rf_req_index), 32'(exp_idx));
        chk("rf_req_tag", 32'(rf_req_tag), 32'(exp_tag));
        chk("rf_req_way", 32'(rf_req_way), 32'(exp_way));
      end
      if (exp_addr_chk) chk("tr_addr", 32'(tr_addr), 32'(exp_idx));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic cyc_cap(output logic o_hit, output logic [1:0] o_way);
    @(negedge clk);
    o_hit = resp_hit;
    o_way = resp_way;
    @(posedge clk); #1;
  endtask

  // One complete lookup transaction, stimulus and expectations cycle by cycle.
  task automatic lookup(input int idx, input logic [TL-1:0] tag, input int rdy_dly,
                        input int done_dly, input bit early,
                        output logic o_hit, output logic [1:0] o_way);
    int hw, v;
    bit from_repl;
    hw = -1;
    for (int w = 0; w < 4; w++)
      if (hw < 0 && mvalid[idx][w] && mtag[idx][w] == tag) hw = w;
    exp_idx = 8'(idx);
    exp_tag = tag;
    req_valid = 1'b1; req_index = 8'(idx); req_tag = tag;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    cyc();
    req_valid = 1'($urandom_range(0, 1)); req_index = 8'($urandom); req_tag = TL'($urandom);
    set_exp(0, 0, 0, 0, 0, 0, 1);
    cyc();
    if (hw >= 0) begin
      req_valid = 1'b0;
      set_exp(1, 1, 1, 2'(hw), 0, 0, 1);
      touch(idx, hw, 1'b0);
      cyc_cap(o_hit, o_way);
    end else begin
      v = -1;
      for (int w = 0; w < 4; w++) if (v < 0 && !mvalid[idx][w]) v = w;
      from_repl = (v < 0);
      if (from_repl) v = policy_victim(idx);
      for (int i = 0; i <= rdy_dly; i++) begin
        rf_req_ready = (i == rdy_dly);
        rf_done = early && (i == 0 || i == rdy_dly);
        set_exp(0, 0, 0, 2'(v), 0, 1, 1);
        cyc();
      end
      rf_req_ready = 1'b0;
      for (int i = 0; i <= done_dly; i++) begin
        rf_done = (i == done_dly);
        set_exp(0, 0, 0, 2'(v), 0, 0, 1);
        cyc();
      end
      rf_done = 1'b0;
      set_exp(0, 1, 0, 2'(v), 1, 0, 1);
      mvalid[idx][v] = 1'b1;
      mtag[idx][v] = tag;
      touch(idx, v, from_repl);
      cyc_cap(o_hit, o_way);
    end
    req_valid = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0, 0);
  endtask

  logic       o_hit;
  logic [1:0] o_way;

  initial begin
    req_valid = 1'b0; req_index = '0; req_tag = '0;
    rf_req_ready = 1'b0; rf_done = 1'b0;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    exp_idx = '0; exp_tag = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_tr_we", 32'(tr_we), 32'd0);
    chk("rst_rf_req_valid", 32'(rf_req_valid), 32'd0);
    chk("rst_tr_addr", 32'(tr_addr), 32'd0);
    chk("rst_tr_din", 32'(tr_din), 32'd0);
    tram_init = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Set 5 holds tag 0 in RAM but nothing is valid yet
    lookup(5, 20'h0, 0, 0, 0, o_hit, o_way);
    chk("first_miss_hit", 32'(o_hit), 32'd0);
    chk("first_miss_way", 32'(o_way), 32'd0);
    lookup(5, 20'h0, 0, 0, 0, o_hit, o_way);
    chk("rehit_hit", 32'(o_hit), 32'd1);
    chk("rehit_way", 32'(o_way), 32'd0);

    for (int k = 0; k < 4; k++) begin
      lookup(9, 20'h100 + TL'(k), k % 2, k, 0, o_hit, o_way);
      chk("set9_fill_way", 32'(o_way), 32'(k));
    end
    lookup(9, 20'h104, 5, 2, 1, o_hit, o_way);
    chk("set9_full_victim0", 32'(o_way), 32'd0);
    lookup(9, 20'h105, 0, 1, 0, o_hit, o_way);
`ifdef CACHE_TAG_CTRL_PLRU_EN
    chk("set9_next_victim", 32'(o_way), 32'd2);
    for (int k = 0; k < 4; k++) lookup(3, 20'h300 + TL'(k), 0, 0, 0, o_hit, o_way);
    lookup(3, 20'h300, 0, 0, 0, o_hit, o_way);
    chk("plru_hit_way0", 32'(o_way), 32'd0);
    lookup(3, 20'h304, 0, 0, 0, o_hit, o_way);
    chk("plru_victim", 32'(o_way), 32'd2);
`else
    chk("set9_next_victim", 32'(o_way), 32'd1);
`endif
    lookup(9, 20'h104, 0, 0, 0, o_hit, o_way);
    chk("set9_hit_104", 32'(o_hit), 32'd1);

    for (int n = 0; n < 300; n++) begin
      int idx;
      case ($urandom_range(0, 3))
        0: idx = 9;
        1: idx = 5;
        2: idx = 3;
        default: idx = int'($urandom_range(0, 255));
      endcase
      lookup(idx, TL'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), o_hit, o_way);
    end

    // Abort a refill by reset while waiting for rf_done
    chk_en = 1'b0;
    req_valid = 1'b1; req_index = 8'd7; req_tag = 20'h55;
    cyc();
    req_valid = 1'b0;
    cyc();
    rf_req_ready = 1'b1;
    chk("abort_rf_valid", 32'(rf_req_valid), 32'd1);
    cyc();
    rf_req_ready = 1'b0;
    cyc();
    #2 resetn = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_rf_req_valid", 32'(rf_req_valid), 32'd0);
    chk("abort_tr_we", 32'(tr_we), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_tr_addr", 32'(tr_addr), 32'd0);
    chk("abort_rf_req_tag", 32'(rf_req_tag), 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    set_exp(1, 0, 0, 0, 0, 0, 0);
    exp_idx = '0; exp_tag = '0;
    cyc();
    chk_en = 1'b1;
    lookup(5, 20'h0, 1, 1, 0, o_hit, o_way);
    chk("post_reset_miss_hit", 32'(o_hit), 32'd0);
    chk("post_reset_miss_way", 32'(o_way), 32'd0);
    cyc();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Lookup/refill controller on the tag side of the 4-way set-associative cache.
- Accepts lookup requests and compares the request tag against the 4-way tag read of the tag RAM.
- On a miss, picks a victim way, requests a refill and then writes the new tag back into the tag RAM (we/way/addr/din).
- Owns the per-way valid bits; the tag RAM holds tags only.

Parameters:
- N, 4: ways. Fixed at 4 because the tag RAM output is a hard 4-way concatenation.
- LOG_W, 2: way-index width.
- LOG_H, 8: set-index width; H = 2**LOG_H sets.
- TAG_LEN, 20: tag width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  controller idle, can accept a request.
- req_index  in  LOG_H  set index.
- req_tag  in  TAG_LEN  request tag.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  1 = hit, 0 = miss-filled.
- resp_way  out  LOG_W  hit way or filled way.
- tr_we  out  1  tag RAM write enable.
- tr_way  out  LOG_W  tag RAM write way.
- tr_addr  out  LOG_H  tag RAM set address.
- tr_din  out  TAG_LEN  tag RAM write data.
- tr_dout  in  N*TAG_LEN  tag RAM read data; way 0 in the LSBs; combinational on tr_addr.
- rf_req_valid  out  1  refill request.
- rf_req_ready  in  1  refill request accepted.
- rf_req_index  out  LOG_H  refill set.
- rf_req_tag  out  TAG_LEN  refill tag.
- rf_req_way  out  LOG_W  refill way.
- rf_done  in  1  refill data written; one-cycle pulse.

Behaviour:
- Reset, asynchronous and active-low:
  - State = IDLE; all valid bits = 0; replacement state = 0.
  - Index/tag/victim registers = 0.
  - Outputs: req_ready=1; resp_valid=0, resp_hit=0, resp_way=0; tr_we=0, tr_way=0, tr_din=0; rf_req_valid=0.
- Address path: tr_addr, rf_req_index, tr_din and rf_req_tag are always driven from the latched index/tag registers.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_index and req_tag, go to LOOKUP.
- LOOKUP (one cycle, compare on tr_dout):
  - hit_w = valid[idx][w] & (tr_dout[w*TAG_LEN+:TAG_LEN]==tag).
  - Any hit: resp_valid=1, resp_hit=1, resp_way = lowest hitting way; update replacement state; go to IDLE.
  - Latency: request accepted at edge k, hit response in the cycle after edge k+1.
  - No hit: victim = lowest-numbered invalid way; if all 4 ways are valid, victim = replacement choice. Latch victim, go to RF_REQ.
- RF_REQ:
  - rf_req_valid=1, with index/tag/way held stable until rf_req_ready.
  - On the accepting edge go to RF_WAIT.
- RF_WAIT:
  - Wait for rf_done, then go to WRITE.
  - rf_done outside RF_WAIT is ignored.
  - rf_done in the same cycle as rf_req_ready is not counted.
- WRITE (one cycle):
  - tr_we=1, tr_way=victim, tr_din=tag; set valid[idx][victim].
  - resp_valid=1, resp_hit=0, resp_way=victim; update replacement state; go to IDLE.
  - Miss latency = 4 cycles plus refill wait cycles.
- Hazards and flow:
  - Back-to-back requests: req_ready returns high in IDLE the cycle after the response. No request overlap and no bypass are needed, since the tag written in WRITE is visible on tr_dout for the next lookup.
  - req_ready=0 in every state except IDLE; req_valid in other states is ignored.
- Round-robin replacement (default):
  - One global LOG_W-bit counter.
  - Increments (3→0 wrap) only when a victim is taken from it, i.e. all ways valid.
- Reset mid-operation: abort immediately to the reset values. An outstanding refill is abandoned; the refill agent must also be reset.
- Multiple ways hitting cannot occur by construction; if it does, the lowest way wins.

Optional Feature:
CACHE_TAG_CTRL_PLRU_EN
- Defined:
  - Replace the global counter with a 3-bit tree-PLRU per set: b0 = root, b1 = ways 0/1, b2 = ways 2/3.
  - On a hit or fill to way w: point the bits away from w.
  - Victim: follow the bits (root 0 → left pair).
  - Reset clears all bits (victim way 0).
- Undefined: global round-robin as above; the PLRU array is absent.

Decomposition:
- Shared package/defs:
  - LOG_W, LOG_H, TAG_LEN, N, H.
  - State encoding: IDLE=0, LOOKUP=1, RF_REQ=2, RF_WAIT=3, WRITE=4.
- Sub-module cache_repl_sel:
  - Holds the replacement state and returns the victim for an index.
  - Update port: index, way, enable.
  - Contains both policy variants under the macro.

Test Plan:
- After reset: lookup idx=5, tag=0 → miss despite tag RAM holding 0 (valid=0). Victim way 0; rf_req idx=5/tag=0/way=0; after rf_done, tr_we=1 way 0; resp hit=0 way=0.
- Re-lookup idx=5, tag=0 → resp_valid the cycle after LOOKUP entry, hit=1, way=0, no rf_req.
- Fill idx=9 with tags 0x100..0x103 → ways 0..3 in order. Then tag 0x104 → all ways valid, round-robin victim way 0; the next miss in set 9 picks way 1.
- Hold rf_req_ready=0 for 5 cycles → rf_req_valid and its payload stay stable; pulse rf_done early → ignored.
- Assert resetn=0 mid RF_WAIT → all outputs go to reset values immediately; the previously filled idx=5 now misses.
- With CACHE_TAG_CTRL_PLRU_EN: fill set 3 with ways 0–3, hit way 0, then miss → victim way 2.
